uart_xcvr_param: RTL and testbench

UART_XCVR_PARAM -- requirements
Module: uart_xcvr_param

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx.sv | 120 ++++++++++++
 rtl/uart_xcvr_param.sv | 190 +++++++++++++++++++
 tb/tb_uart_xcvr_param.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, transmitter/receiver state encodings,
// rx_status bit positions and the parity helper used by both directions.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int STATUS_PARITY  = 0;
    localparam int STATUS_FRAMING = 1;
    localparam int STATUS_OVERRUN = 2;

    localparam int MAX_WORD_BITS = 9;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_WORD_BITS-1:0] data,
                                         input parity_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Emits a one-cycle done pulse with the word and its parity/framing flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int      CLOCKS_PER_PULSE = 5208,
    parameter int      BITS_PER_WORD    = 8,
    parameter parity_e PARITY_MODE      = PAR_NONE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    output logic                     done_o,
    output logic [BITS_PER_WORD-1:0] data_o,
    output logic                     parity_err_o,
    output logic                     framing_err_o
);

    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int IDX_W = $clog2(BITS_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    // Preloading with CPP - CPP/2 puts the start-bit sample CPP/2 cycles after the
    // edge; every later sample then follows one full bit period after the previous.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLOCKS_PER_PULSE - CLOCKS_PER_PULSE / 2);

    logic                     rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BITS_PER_WORD-1:0] data_q, data_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     done_q, done_d;
    logic                     sample_now;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
        end
    end

    assign sample_now = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = sample_now ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = CNT_START;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (sample_now) begin
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample_now) begin
                    data_d = {rx_sync_q, data_q[BITS_PER_WORD-1:1]};
                    if (idx_q == IDX_W'(BITS_PER_WORD - 1)) begin
                        state_d = (PARITY_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (sample_now) begin
                    perr_d  = (rx_sync_q != calc_parity(MAX_WORD_BITS'(data_q), PARITY_MODE));
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample_now) begin
                    ferr_d  = !rx_sync_q;
                    done_d  = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign done_o        = done_q;
    assign data_o        = data_q;
    assign parity_err_o  = perr_q;
    assign framing_err_o = ferr_q;

endmodule

// File: rtl/uart_xcvr_param.sv
// Parameterised UART transceiver: transmitter FSM, receive holding register and
// rx handshake here; bit-level reception lives in uart_rx.
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int      CLOCKS_PER_PULSE = 5208,
    parameter int      BITS_PER_WORD    = 8,
    parameter parity_e PARITY_MODE      = PAR_NONE,
    parameter int      STOP_BITS        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS_PER_WORD-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [2:0]               rx_status
);

    if (CLOCKS_PER_PULSE < 8) begin : g_bad_cpp
        $error("uart_xcvr_param: CLOCKS_PER_PULSE must be >= 8");
    end
    if (BITS_PER_WORD < 5 || BITS_PER_WORD > 9) begin : g_bad_bpw
        $error("uart_xcvr_param: BITS_PER_WORD must be 5..9");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_par
        $error("uart_xcvr_param: PARITY_MODE must be PAR_NONE, PAR_EVEN or PAR_ODD");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_xcvr_param: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int IDX_W = $clog2(BITS_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_STOP_LAST = CNT_W'(CLOCKS_PER_PULSE - 2);

    // ---------------- transmitter ----------------
    tx_state_e                tx_state_q, tx_state_d;
    logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]         tx_idx_q, tx_idx_d;
    logic [BITS_PER_WORD-1:0] tx_shift_q, tx_shift_d;
    logic                     tx_par_q, tx_par_d;
    logic                     tx_stop_q, tx_stop_d;
    logic                     tx_tick, tx_line;

    // Both directions use valid/ready: a word moves on the cycle where valid && ready
    // are both high; the producer holds valid and data stable until that cycle.
    assign tx_ready = !rst && (tx_state_q == TX_IDLE);
    assign tx_tick  = (tx_cnt_q == CNT_LAST);
    assign tx       = rst ? 1'b1 : tx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        tx_line    = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_valid && tx_ready) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_par_d   = calc_parity(MAX_WORD_BITS'(tx_data), PARITY_MODE);
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_stop_d  = 1'b0;
                    if (tx_idx_q == IDX_W'(BITS_PER_WORD - 1)) begin
                        tx_state_d = (PARITY_MODE == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_idx_d = tx_idx_q + IDX_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                tx_line = tx_par_q;
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = 1'b0;
                end
            end
            TX_STOP: begin
                // The final stop-bit cycle is spent in IDLE (line already high), so a
                // waiting word starts its start bit with no extra idle cycle.
                if (tx_stop_q == 1'(STOP_BITS - 1) && tx_cnt_q == CNT_STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else if (tx_tick) begin
                    tx_stop_d = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- receiver + holding register ----------------
    logic                     rx_done, rx_perr, rx_ferr;
    logic [BITS_PER_WORD-1:0] rx_word;
    logic                     rx_valid_q, rx_valid_d;
    logic [BITS_PER_WORD-1:0] rx_data_q, rx_data_d;
    logic [2:0]               rx_status_q, rx_status_d;
    logic                     rx_consume;

    uart_rx #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .PARITY_MODE     (PARITY_MODE)
    ) u_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .done_o       (rx_done),
        .data_o       (rx_word),
        .parity_err_o (rx_perr),
        .framing_err_o(rx_ferr)
    );

    assign rx_consume = rx_valid_q && rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_status_q <= '0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_status_q <= rx_status_d;
        end
    end

    always_comb begin
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_status_d = rx_status_q;
        if (rx_done && (!rx_valid_q || rx_consume)) begin
            rx_valid_d                  = 1'b1;
            rx_data_d                   = rx_word;
            rx_status_d                 = '0;
            rx_status_d[STATUS_PARITY]  = rx_perr;
            rx_status_d[STATUS_FRAMING] = rx_ferr;
        end else if (rx_done) begin
            rx_status_d[STATUS_OVERRUN] = 1'b1;
        end else if (rx_consume) begin
            rx_valid_d  = 1'b0;
            rx_status_d = '0;
        end
    end

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench for uart_xcvr_param: 8N1 loopback instance, 7E2 transmitter
// instance (self-looped) and 8O1 receiver instance driven bit by bit.
module tb_uart_xcvr_param;
    import uart_pkg::*;

    localparam int CPP = 16;
    localparam int TMO = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8N1
    logic [7:0] a_tx_data, a_rx_data;
    logic       a_tx_valid, a_tx_ready, a_tx, a_rx, a_rx_valid, a_rx_ready;
    logic [2:0] a_rx_status;
    logic       a_loop, a_rx_drv;
    assign a_rx = a_loop ? a_tx : a_rx_drv;

    // 7E2
    logic [6:0] b_tx_data, b_rx_data;
    logic       b_tx_valid, b_tx_ready, b_tx, b_rx_valid, b_rx_ready;
    logic [2:0] b_rx_status;

    // 8O1
    logic [7:0] c_tx_data, c_rx_data;
    logic       c_tx_valid, c_tx_ready, c_tx, c_rx_valid, c_rx_ready, c_rx_drv;
    logic [2:0] c_rx_status;

    uart_xcvr_param #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8),
                      .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_status(a_rx_status)
    );

    uart_xcvr_param #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(7),
                      .PARITY_MODE(PAR_EVEN), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .tx(b_tx), .rx(b_tx), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_status(b_rx_status)
    );

    uart_xcvr_param #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8),
                      .PARITY_MODE(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_data(c_tx_data), .tx_valid(c_tx_valid),
        .tx_ready(c_tx_ready), .tx(c_tx), .rx(c_rx_drv), .rx_data(c_rx_data),
        .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_status(c_rx_status)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits are sent LSB of 'bits' first, each held for one bit period.
    task automatic drive_serial(input logic [11:0] bits, input int nbits, input bit to_c);
        for (int i = 0; i < nbits; i++) begin
            if (to_c) c_rx_drv = bits[i];
            else      a_rx_drv = bits[i];
            tick(CPP);
        end
        if (to_c) c_rx_drv = 1'b1;
        else      a_rx_drv = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [10:0] b_exp;

        rst = 1'b1;
        a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b0; a_loop = 1'b1; a_rx_drv = 1'b1;
        b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
        c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b0; c_rx_drv = 1'b1;
        tick(3);

        // reset state
        check("rst_tx", a_tx, 1'b1);
        check("rst_tx_ready", a_tx_ready, 1'b0);
        check("rst_rx_valid", a_rx_valid, 1'b0);
        check("rst_rx_data", a_rx_data, 8'h00);
        check("rst_rx_status", a_rx_status, 3'b000);
        rst = 1'b0;
        #1;
        check("tx_ready_after_rst", a_tx_ready, 1'b1);
        check("tx_ready_after_rst_7e2", b_tx_ready, 1'b1);
        check("tx_ready_after_rst_8o1", c_tx_ready, 1'b1);
        check("idle_tx_8o1", c_tx, 1'b1);
        tick(1);

        // 8N1 loopback 0xA5
        a_tx_data = 8'hA5; a_tx_valid = 1'b1;
        tick(1);
        a_tx_valid = 1'b0;
        check("a5_start_low", a_tx, 1'b0);
        check("a5_ready_low", a_tx_ready, 1'b0);
        n = 0;
        while (a_rx_valid !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("a5_rx_latency", n, 156);
        check("a5_rx_data", a_rx_data, 8'hA5);
        check("a5_rx_status", a_rx_status, 3'b000);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        check("a5_consumed", a_rx_valid, 1'b0);
        n = 0;
        while (a_tx_ready !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("a5_tx_idle_timeout", n < TMO, 1'b1);

        // back-to-back 0x11, 0x22 with rx_ready low: overrun
        a_tx_data = 8'h11; a_tx_valid = 1'b1;
        tick(1);
        check("b2b_first_start", a_tx, 1'b0);
        a_tx_data = 8'h22;
        n = 0;
        while (a_tx_ready !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("b2b_frame_len", n, 159);
        tick(1);
        a_tx_valid = 1'b0;
        check("b2b_no_idle_gap", a_tx, 1'b0);
        n = 0;
        while (a_tx_ready !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("b2b_second_len", n, 159);
        check("ovr_rx_valid", a_rx_valid, 1'b1);
        check("ovr_rx_data", a_rx_data, 8'h11);
        check("ovr_rx_status", a_rx_status, 3'b100);

        // consumption coincides with completion of 0x5A
        a_tx_data = 8'h5A; a_tx_valid = 1'b1;
        tick(1);
        a_tx_valid = 1'b0;
        tick(155);
        check("same_cycle_old_word", a_rx_data, 8'h11);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        check("same_cycle_valid", a_rx_valid, 1'b1);
        check("same_cycle_data", a_rx_data, 8'h5A);
        check("same_cycle_status", a_rx_status, 3'b000);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        check("same_cycle_consumed", a_rx_valid, 1'b0);
        n = 0;
        while (a_tx_ready !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("5a_tx_idle_timeout", n < TMO, 1'b1);

        // 4-cycle glitch, then a frame with a low stop bit
        a_loop = 1'b0; a_rx_drv = 1'b1;
        tick(2);
        a_rx_drv = 1'b0; tick(4); a_rx_drv = 1'b1;
        tick(40);
        check("glitch_no_valid", a_rx_valid, 1'b0);
        check("glitch_no_status", a_rx_status, 3'b000);
        drive_serial({2'b00, 1'b0, 8'h66, 1'b0}, 10, 1'b0);
        n = 0;
        while (a_rx_valid !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("ferr_rx_valid", a_rx_valid, 1'b1);
        check("ferr_rx_data", a_rx_data, 8'h66);
        check("ferr_rx_status", a_rx_status, 3'b010);
        a_rx_ready = 1'b1; tick(1); a_rx_ready = 1'b0;
        check("ferr_status_cleared", a_rx_status, 3'b000);
        a_loop = 1'b1;
        tick(4);

        // 7E2 transmit of 0x41: start, 1000001, parity 0, two stops
        b_exp = {1'b1, 1'b1, 1'b0, 7'h41, 1'b0};
        b_tx_data = 7'h41; b_tx_valid = 1'b1;
        tick(1);
        b_tx_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < CPP; j++) begin
                check($sformatf("7e2_bit%0d_cyc%0d", i, j), b_tx, b_exp[i]);
                tick(1);
            end
        end
        check("7e2_rx_valid", b_rx_valid, 1'b1);
        check("7e2_rx_data", b_rx_data, 7'h41);
        check("7e2_rx_status", b_rx_status, 3'b000);

        // 8O1 receive: good parity, then inverted parity
        drive_serial({1'b0, 1'b1, 1'b0, 8'h37, 1'b0}, 11, 1'b1);
        n = 0;
        while (c_rx_valid !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("8o1_good_data", c_rx_data, 8'h37);
        check("8o1_good_status", c_rx_status, 3'b000);
        c_rx_ready = 1'b1; tick(1); c_rx_ready = 1'b0;
        check("8o1_good_consumed", c_rx_valid, 1'b0);
        drive_serial({1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 1'b1);
        n = 0;
        while (c_rx_valid !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("8o1_bad_valid", c_rx_valid, 1'b1);
        check("8o1_bad_data", c_rx_data, 8'h5A);
        check("8o1_bad_status", c_rx_status, 3'b001);

        // reset mid-DATA, then a clean 0x3C
        a_tx_data = 8'h00; a_tx_valid = 1'b1;
        tick(1);
        a_tx_valid = 1'b0;
        tick(40);
        check("mid_data_low", a_tx, 1'b0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_tx_high", a_tx, 1'b1);
        check("mid_rst_ready_low", a_tx_ready, 1'b0);
        check("mid_rst_rx_status", c_rx_status, 3'b000);
        tick(2);
        rst = 1'b0;
        #1;
        check("post_rst_ready", a_tx_ready, 1'b1);
        tick(1);
        a_tx_data = 8'h3C; a_tx_valid = 1'b1;
        tick(1);
        a_tx_valid = 1'b0;
        n = 0;
        while (a_rx_valid !== 1'b1 && n < TMO) begin tick(1); n++; end
        check("3c_rx_latency", n, 156);
        check("3c_rx_data", a_rx_data, 8'h3C);
        check("3c_rx_status", a_rx_status, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
